// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Collects edge-triggered interrupt requests. It latches them as pending events and
// presents one qualified request (OnInt) to the microcode interrupt dispatch. The
// microcode answers with a handshake on IntAck, then DrData, then LdEnInt.
//
// On acknowledge, the controller:
//   - selects the lowest-index pending, unmasked source;
//   - clears that source's pending bit;
//   - disables further interrupts;
//   - latches the source's vector word (VEC_BASE + index) for the datapath bus.
//
// An acknowledge with nothing qualified latches the spurious vector VEC_BASE + NUM_SRC.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   irq       request lines, rising-edge sensitive
//   LdMask    load mask register from DataIn[NUM_SRC-1:0] (1 = source enabled)
//   DataIn    datapath bus value
//   LdEnInt   load interrupt-enable flag from EnIntVal
//   EnIntVal  enable value (1 = EI/RETI, 0 = DI)
//   IntAck    acknowledge strobe
//   DrData    request to drive the vector onto the bus
//   OnInt     registered qualified interrupt request
//   DataOut   latched vector, valid while DataOE = 1
//   DataOE    bus drive enable (combinational from DrData while serving)
//   EnInt     current enable flag
//   Pending   pending register
module interrupt_controller #(
    parameter int unsigned      NUM_SRC  = 4,
    parameter int unsigned      DATA_W   = 32,
    parameter logic [DATA_W-1:0] VEC_BASE = 'h0000_0100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               LdMask,
    input  logic [DATA_W-1:0]  DataIn,
    input  logic               LdEnInt,
    input  logic               EnIntVal,
    input  logic               IntAck,
    input  logic               DrData,
    output logic               OnInt,
    output logic [DATA_W-1:0]  DataOut,
    output logic               DataOE,
    output logic               EnInt,
    output logic [NUM_SRC-1:0] Pending
);

    localparam int unsigned SelW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        StIdle,
        StServe
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_SRC-1:0]  irq_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  mask_q, mask_d;
    logic [DATA_W-1:0]   vec_q, vec_d;
    logic                en_q, en_d;
    logic                onint_q, onint_d;

    logic [NUM_SRC-1:0]  rise;
    logic [NUM_SRC-1:0]  req;
    logic                qual;
    logic [SelW-1:0]     sel;
    logic [NUM_SRC-1:0]  clr_mask;

    assign rise = irq & ~irq_q;
    assign req  = pending_q & mask_q;
    assign qual = |req;

    // Lowest index wins: scan downwards so the last hit is the lowest set bit.
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel = SelW'(i);
            end
        end
    end

    // Bits of DataIn above the mask width are not used by this block.
    if (DATA_W > NUM_SRC) begin : gen_unused
        logic unused_data_hi;
        assign unused_data_hi = ^DataIn[DATA_W-1:NUM_SRC];
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        vec_d    = vec_q;
        onint_d  = 1'b0;
        clr_mask = '0;
        mask_d   = LdMask ? DataIn[NUM_SRC-1:0] : mask_q;

        unique case (state_q)
            StIdle: begin
                onint_d = en_q & qual;
                if (IntAck) begin
                    // Acknowledge takes priority over a simultaneous LdEnInt.
                    if (qual) begin
                        vec_d    = VEC_BASE + DATA_W'(sel);
                        clr_mask = NUM_SRC'(1) << sel;
                    end else begin
                        vec_d = VEC_BASE + DATA_W'(NUM_SRC);
                    end
                    en_d    = 1'b0;
                    state_d = StServe;
                end else if (LdEnInt) begin
                    en_d = EnIntVal;
                end
            end
            StServe: begin
                // IntAck is ignored here. Only an EI/RETI load ends service.
                if (LdEnInt && EnIntVal) begin
                    en_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new rise on the source being cleared survives the clear.
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            vec_q     <= '0;
            en_q      <= 1'b0;
            onint_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
            en_q      <= en_d;
            onint_q   <= onint_d;
        end
    end

    assign OnInt   = onint_q;
    assign EnInt   = en_q;
    assign Pending = pending_q;
    assign DataOut = vec_q;
    assign DataOE  = (state_q == StServe) & DrData;

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized scoreboard bench for interrupt_controller.
//
// The stimulus process advances a behavioural model once per clock and queues the
// expected outputs. A separate monitor pops each entry and compares it against the DUT
// on the falling edge.
module tb_interrupt_controller;

    localparam int unsigned N       = 4;
    localparam int unsigned W       = 32;
    localparam logic [31:0] BASE    = 32'h0000_0100;
    localparam int          NCYCLES = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq;
    logic          LdMask;
    logic [W-1:0]  DataIn;
    logic          LdEnInt;
    logic          EnIntVal;
    logic          IntAck;
    logic          DrData;
    logic          OnInt;
    logic [W-1:0]  DataOut;
    logic          DataOE;
    logic          EnInt;
    logic [N-1:0]  Pending;

    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_SRC  (N),
        .DATA_W   (W),
        .VEC_BASE (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq      (irq),
        .LdMask   (LdMask),
        .DataIn   (DataIn),
        .LdEnInt  (LdEnInt),
        .EnIntVal (EnIntVal),
        .IntAck   (IntAck),
        .DrData   (DrData),
        .OnInt    (OnInt),
        .DataOut  (DataOut),
        .DataOE   (DataOE),
        .EnInt    (EnInt),
        .Pending  (Pending)
    );

    typedef struct {
        bit          onint;
        bit          en;
        bit          oe;
        bit          chk_data;
        bit [N-1:0]  pend;
        bit [31:0]   data;
    } exp_t;

    exp_t exp_q[$];
    bit   stim_done = 1'b0;

    // Reference model state.
    bit          m_serving;
    bit          m_prev_irq[N];
    bit          m_pend[N];
    bit          m_mask[N];
    bit          m_en;
    bit          m_onint;
    bit [31:0]   m_vec;
    bit          m_just_reset;

    // Apply one clock edge using the inputs currently on the pins.
    task automatic model_step();
        int  winner;
        bit  new_pend[N];
        if (!rst) begin
            m_serving = 1'b0;
            m_en      = 1'b0;
            m_onint   = 1'b0;
            m_vec     = 32'd0;
            for (int i = 0; i < N; i++) begin
                m_prev_irq[i] = 1'b0;
                m_pend[i]     = 1'b0;
                m_mask[i]     = 1'b0;
            end
            m_just_reset = 1'b1;
            return;
        end
        m_just_reset = 1'b0;

        // Lowest-index source that is both pending and enabled, or -1.
        winner = -1;
        for (int i = 0; i < N; i++) begin
            if (winner < 0 && m_pend[i] && m_mask[i]) winner = i;
        end

        // Latch new rising edges into the pending set.
        for (int i = 0; i < N; i++) begin
            new_pend[i] = m_pend[i] || (irq[i] && !m_prev_irq[i]);
        end

        if (!m_serving) begin
            m_onint = m_en && (winner >= 0);
            if (IntAck) begin
                if (winner >= 0) begin
                    m_vec = BASE + winner;
                    // A new rise on the acked source keeps it pending.
                    new_pend[winner] = irq[winner] && !m_prev_irq[winner];
                end else begin
                    m_vec = BASE + N;
                end
                m_en      = 1'b0;
                m_serving = 1'b1;
            end else if (LdEnInt) begin
                m_en = EnIntVal;
            end
        end else begin
            m_onint = 1'b0;
            if (LdEnInt && EnIntVal) begin
                m_en      = 1'b1;
                m_serving = 1'b0;
            end
        end

        for (int i = 0; i < N; i++) begin
            m_pend[i]     = new_pend[i];
            m_prev_irq[i] = irq[i];
            if (LdMask) m_mask[i] = DataIn[i];
        end
    endtask

    task automatic randomize_inputs(input bit force_reset);
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) irq[i] = ~irq[i];
        end
        rst      = force_reset ? 1'b0 : ($urandom_range(0, 249) != 0);
        LdMask   = ($urandom_range(0, 15) == 0);
        DataIn   = $urandom;
        if ($urandom_range(0, 1) == 0) DataIn[3:0] = 4'hF;
        LdEnInt  = ($urandom_range(0, 4) == 0);
        EnIntVal = ($urandom_range(0, 3) != 0);
        IntAck   = ($urandom_range(0, 5) == 0);
        DrData   = $urandom_range(0, 1);
    endtask

    // Stimulus and reference model.
    initial begin
        exp_t e;
        rst      = 1'b0;
        irq      = '0;
        LdMask   = 1'b0;
        DataIn   = '0;
        LdEnInt  = 1'b0;
        EnIntVal = 1'b0;
        IntAck   = 1'b0;
        DrData   = 1'b1;
        for (int c = 0; c < NCYCLES; c++) begin
            @(posedge clk);
            #1;
            model_step();
            if (c < 2) begin
                randomize_inputs(1'b1);
            end else if (c == 2) begin
                randomize_inputs(1'b0);
                rst      = 1'b1;
                LdMask   = 1'b1;
                DataIn   = 32'h0000_000F;
                LdEnInt  = 1'b1;
                EnIntVal = 1'b1;
                IntAck   = 1'b0;
            end else begin
                randomize_inputs(1'b0);
            end
            e.onint = m_onint;
            e.en    = m_en;
            e.oe    = m_serving && DrData;
            for (int i = 0; i < N; i++) e.pend[i] = m_pend[i];
            e.data     = m_vec;
            e.chk_data = e.oe || m_just_reset;
            exp_q.push_back(e);
        end
        stim_done = 1'b1;
    end

    // Monitor and scoreboard.
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        int   edges = 0;
        forever begin
            @(negedge clk);
            edges++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("OnInt",   {31'd0, OnInt},   {31'd0, e.onint});
                chk("EnInt",   {31'd0, EnInt},   {31'd0, e.en});
                chk("Pending", {28'd0, Pending}, {28'd0, e.pend});
                chk("DataOE",  {31'd0, DataOE},  {31'd0, e.oe});
                if (e.chk_data) chk("DataOut", DataOut, e.data);
            end
            if (stim_done && exp_q.size() == 0) break;
            if (edges > NCYCLES + 50) begin
                n_err++;
                $display("FAIL timeout: %0d expectations left, required 0", exp_q.size());
                break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
